vga_register_display: RTL and testbench
=======================================

Name: vga_register_display

Overview:
- Read-side consumer of the register file's 176-bit debug bus.
- Generates 640x480@60 VGA timing from the system clock and renders the 11 registers as a column of 4-digit hex words: R0-R7, IH, SP, RA, top to bottom.
- Latches a snapshot of the bus once per frame so a frame never shows mixed register values.
- Sits beside the CPU core and drives the board VGA connector: 3 bits per colour, negative syncs.

Parameters:
- CLK_DIV, 2, system clocks per pixel. Pixel enable asserts once every CLK_DIV cycles.
- X0, 64, left pixel column of the text area.
- Y0, 48, top pixel line of the text area.

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  reset.
- registersVGA  in  176  register dump. [175:160]=R0 … [15:0]=RA (index 10).
- hs  out  1  horizontal sync, active low.
- vs  out  1  vertical sync, active low.
- r  out  3  red.
- g  out  3  green.
- b  out  3  blue.

Behaviour:
- Reset: rst is asynchronous, active-low.
  - While rst=0: hs=1, vs=1, r=g=b=0.
  - Divider, hcnt, vcnt and snapshot are all 0.
  - Reset mid-frame aborts the frame immediately. Timing restarts at hcnt=0, vcnt=0 on release.
- Pixel enable (pe):
  - The divider counts 0..CLK_DIV-1; pe=1 when it equals CLK_DIV-1.
  - First pe occurs CLK_DIV cycles after reset release.
  - hcnt/vcnt advance only on pe.
- Horizontal counter hcnt 0..799, wraps to 0. vcnt increments on the hcnt 799->0 wrap.
- Vertical counter vcnt 0..524, wraps to 0.
- Sync and active video (combinational, from the counters):
  - hs low for hcnt 656..751 (96 px).
  - vs low for vcnt 490..491 (2 lines).
  - Active video when hcnt<640 and vcnt<480.
- Snapshot:
  - Captures registersVGA on the pe that moves the counters to hcnt=0, vcnt=480 (start of vertical blank).
  - Holds until the next such event.
  - Bus changes at any other time have no visible effect until the following frame.
- Text area geometry:
  - Glyphs are 8x8, scaled x2, so each digit cell is 16x16 px.
  - col = (hcnt-X0)>>1 and row = (vcnt-Y0)>>1, valid when 0<=col<32 and 0<=row<88.
  - digit = col[4:3] selects the nibble; digit 0 = bits [15:12].
  - reg = row>>3 selects the word (0..10).
  - gx = col[2:0], gy = row[2:0].
- Glyph ROM (internal, 16 entries x 8 rows x 8 bits):
  - MSB of each row byte is the leftmost pixel.
  - Every glyph has row 7 = 8'h00 and bit 0 = 0 on all rows (inter-character spacing).
  - Fixed rows: '0' row0 = 8'h3C; 'F' row0 = 8'h7E; 'F' row4 = 8'h7C.
  - The full table is the golden model shared with the bench.
- Colour:
  - Active video inside the text area: glyph bit 1 -> r=g=b=7; bit 0 -> r=0, g=0, b=2 (dark blue cell).
  - Active video outside the text area: black.
  - Blanking: r=g=b=0, always.
- Latency and pipelining:
  - hs, vs, r, g, b are registered, updated on pe only, and reflect the counter values of the previous pe.
  - Sync and colour share this same 1-pixel delay, so they stay aligned.
- Widths: hcnt and vcnt are 10 bits. Subtraction for col/row is 10-bit; negative results (wrap to large values) fall outside the valid range and render background.

Test Plan:
1. Hold rst=0 for 10 clk -> hs=1, vs=1, rgb=0 throughout. Release -> first hs fall after (656+1)*2 clk ± divider phase. Low width is exactly 192 clk; period is 1600 clk.
2. Run 2 frames -> vs low for exactly 3200 clk, period 840000 clk. hs keeps running during vs.
3. Set registersVGA[175:160]=16'h1234 before vcnt=480. At frame N+1 change it to 16'hABCD while vcnt=100 -> frame N+1 shows 1234; frame N+2 shows ABCD. Compare every pixel against the font model.
4. Set RA=16'hF000, others 0. At vcnt=208, hcnt=64..79 -> pixels follow 7E doubled: 0011111111111100 (1=white, 0=blue). hcnt=80..95 at vcnt=208 -> pattern 3C doubled.
5. Pixels at hcnt=40, vcnt=100 (outside text area) -> black. Any pixel at hcnt>=640 or vcnt>=480 -> rgb=0 regardless of snapshot.
6. Assert rst at hcnt=300, vcnt=200 for 3 clk -> outputs go to reset values asynchronously. After release, timing matches scenario 1 and the snapshot reads 0 until the next vblank capture.

Source files
------------

// File: rtl/vga_register_display_if.sv
// Bundle between the register file debug bus and the VGA connector:
// the 176-bit register dump going in, syncs and 3-bit colour coming out.
interface vga_register_display_if;
  logic [175:0] registersVGA;
  logic         hs;
  logic         vs;
  logic [2:0]   r;
  logic [2:0]   g;
  logic [2:0]   b;

  modport master (output registersVGA, input hs, vs, r, g, b);
  modport slave  (input registersVGA, output hs, vs, r, g, b);
endinterface

// File: rtl/vga_register_display.sv
// VGA register viewer: generates 640x480@60 timing and draws the 11 CPU registers
// (R0-R7, IH, SP, RA) as 4-digit hex words from a once-per-frame bus snapshot.
module vga_register_display #(
  parameter int CLK_DIV  = 2,
  parameter int X0       = 64,
  parameter int Y0       = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33
) (
  input  logic                   clk,
  input  logic                   rst,
  vga_register_display_if.slave  vga
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);
  localparam logic [9:0] HA       = 10'(H_ACTIVE);
  localparam logic [9:0] VA       = 10'(V_ACTIVE);
  localparam logic [9:0] VA_LAST  = 10'(V_ACTIVE - 1);

  // 8x8 hex glyphs, row 0 in the top byte; bit 0 and row 7 stay clear for spacing.
  function automatic logic [7:0] glyph_row(input logic [3:0] nib, input logic [2:0] gy);
    logic [63:0] g;
    case (nib)
      4'h0:    g = 64'h3C66_6E76_6666_3C00;
      4'h1:    g = 64'h1838_1818_1818_7E00;
      4'h2:    g = 64'h3C66_060C_3060_7E00;
      4'h3:    g = 64'h3C66_061C_0666_3C00;
      4'h4:    g = 64'h0C1C_3C6C_7E0C_0C00;
      4'h5:    g = 64'h7E60_7C06_0666_3C00;
      4'h6:    g = 64'h3C60_607C_6666_3C00;
      4'h7:    g = 64'h7E06_0C18_3030_3000;
      4'h8:    g = 64'h3C66_663C_6666_3C00;
      4'h9:    g = 64'h3C66_663E_060C_3800;
      4'hA:    g = 64'h183C_6666_7E66_6600;
      4'hB:    g = 64'h7C66_667C_6666_7C00;
      4'hC:    g = 64'h3C66_6060_6066_3C00;
      4'hD:    g = 64'h786C_6666_666C_7800;
      4'hE:    g = 64'h7E60_607C_6060_7E00;
      default: g = 64'h7E60_6060_7C60_6000;
    endcase
    return g[{~gy, 3'b000} +: 8];
  endfunction

  logic [DIV_W-1:0] div_q, div_d;
  logic [9:0]       hcnt_q, hcnt_d;
  logic [9:0]       vcnt_q, vcnt_d;
  logic [175:0]     snap_q, snap_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic [2:0]       r_q, r_d;
  logic [2:0]       g_q, g_d;
  logic [2:0]       b_q, b_d;

  logic       pe;
  logic       active;
  logic       in_text;
  logic       pix_on;
  logic [9:0] col_full;
  logic [9:0] row_full;
  logic [8:0] col;
  logic [8:0] row;
  logic [3:0] reg_idx;
  logic [7:0] word_lsb;
  logic [15:0] word;
  logic [3:0] nibble;
  logic [7:0] glyph;

  // Text lookup: a left/above-origin position wraps to a large col/row and drops out.
  always_comb begin
    col_full = hcnt_q - 10'(X0);
    row_full = vcnt_q - 10'(Y0);
    col      = col_full[9:1];
    row      = row_full[9:1];
    in_text  = (col < 9'd32) && (row < 9'd88);
    active   = (hcnt_q < HA) && (vcnt_q < VA);
    reg_idx  = row[6:3];
    word_lsb = '0;
    word     = '0;
    nibble   = '0;
    glyph    = '0;
    pix_on   = 1'b0;
    if (in_text) begin
      word_lsb = {4'd10 - reg_idx, 4'b0000};
      word     = snap_q[word_lsb +: 16];
      nibble   = word[{~col[4:3], 2'b00} +: 4];
      glyph    = glyph_row(nibble, row[2:0]);
      pix_on   = glyph[~col[2:0]];
    end
  end

  always_comb begin
    pe     = (div_q == DIV_LAST);
    div_d  = pe ? '0 : div_q + 1'b1;
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    snap_d = snap_q;
    hs_d   = hs_q;
    vs_d   = vs_q;
    r_d    = r_q;
    g_d    = g_q;
    b_d    = b_q;
    if (pe) begin
      if (hcnt_q == H_LAST) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 10'd1;
        // Capture exactly when the counters enter vertical blank.
        if (vcnt_q == VA_LAST) snap_d = vga.registersVGA;
      end else begin
        hcnt_d = hcnt_q + 10'd1;
      end
      hs_d = !((hcnt_q >= HS_START) && (hcnt_q <= HS_END));
      vs_d = !((vcnt_q >= VS_START) && (vcnt_q <= VS_END));
      r_d  = '0;
      g_d  = '0;
      b_d  = '0;
      if (active && in_text) begin
        if (pix_on) begin
          r_d = 3'd7;
          g_d = 3'd7;
          b_d = 3'd7;
        end else begin
          b_d = 3'd2;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q  <= '0;
      hcnt_q <= '0;
      vcnt_q <= '0;
      snap_q <= '0;
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      r_q    <= '0;
      g_q    <= '0;
      b_q    <= '0;
    end else begin
      div_q  <= div_d;
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      snap_q <= snap_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      r_q    <= r_d;
      g_q    <= g_d;
      b_q    <= b_d;
    end
  end

  assign vga.hs = hs_q;
  assign vga.vs = vs_q;
  assign vga.r  = r_q;
  assign vga.g  = g_q;
  assign vga.b  = b_q;

endmodule

// File: tb/tb_vga_register_display.sv
// Bench for vga_register_display on a shrunken raster so several frames fit in a short run;
// expected output per clock comes from a pixel-index model of timing, font and snapshot.
module tb_vga_register_display;

  localparam int CLK_DIV = 2;
  localparam int X0 = 2;
  localparam int Y0 = 1;
  localparam int HA = 68, HF = 2, HS = 4, HB = 2;
  localparam int VA = 178, VF = 2, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int CAP_K = VA * HT;
  localparam logic [12:0] RST_VAL = 13'b1_1_000_000_000;

  logic clk;
  logic rst;

  vga_register_display_if vif();

  vga_register_display #(
    .CLK_DIV(CLK_DIV), .X0(X0), .Y0(Y0),
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vga(vif)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  logic [63:0] font64 [16];
  logic [15:0] bus_words  [11];
  logic [15:0] snap_words [11];
  int          n_checks = 0;
  int          n_errors = 0;
  int          edges = 0;
  int          k = 0;
  logic [12:0] exp_out = RST_VAL;
  logic [31:0] pat = '0;
  logic        mid_reset_done = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at t=%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic drive_bus();
    for (int i = 0; i < 11; i++) vif.registersVGA[175 - 16*i -: 16] = bus_words[i];
  endtask

  function automatic logic [12:0] pixel_model(input int p);
    int h, v, cx, cy, nib, gx, gy;
    logic [7:0] rowbits;
    logic hs_e, vs_e;
    logic [8:0] rgb;
    h = p % HT;
    v = p / HT;
    hs_e = !(h >= HA + HF && h < HA + HF + HS);
    vs_e = !(v >= VA + VF && v < VA + VF + VS);
    rgb = '0;
    if (h < HA && v < VA) begin
      cx = h - X0;
      cy = v - Y0;
      if (cx >= 0 && cx < 64 && cy >= 0 && cy < 176) begin
        nib = int'((snap_words[cy / 16] >> (12 - 4 * (cx / 16))) & 16'hF);
        gx = (cx % 16) / 2;
        gy = (cy % 16) / 2;
        rowbits = 8'((font64[nib] >> (8 * (7 - gy))) & 64'hFF);
        rgb = rowbits[7 - gx] ? 9'o777 : 9'o002;
      end
    end
    return {hs_e, vs_e, rgb};
  endfunction

  task automatic tick();
    int p;
    @(posedge clk);
    #1;
    if (rst) begin
      edges++;
      if (edges % CLK_DIV == 0) begin
        k = edges / CLK_DIV;
        p = (k - 1) % FRAME;
        exp_out = pixel_model(p);
        if (k % FRAME == CAP_K) snap_words = bus_words;
        if (!mid_reset_done && (k - 1) / FRAME == 1 && p / HT == Y0 + 160
            && p % HT >= X0 && p % HT < X0 + 32)
          pat[31 - (p % HT - X0)] = (vif.r == 3'd7);
      end
    end else begin
      edges = 0;
      k = 0;
      exp_out = RST_VAL;
      for (int i = 0; i < 11; i++) snap_words[i] = '0;
    end
    check("pixel", {19'd0, vif.hs, vif.vs, vif.r, vif.g, vif.b}, {19'd0, exp_out});
  endtask

  initial begin
    font64[0]  = 64'h3C666E7666663C00; font64[1]  = 64'h1838181818187E00;
    font64[2]  = 64'h3C66060C30607E00; font64[3]  = 64'h3C66061C06663C00;
    font64[4]  = 64'h0C1C3C6C7E0C0C00; font64[5]  = 64'h7E607C0606663C00;
    font64[6]  = 64'h3C60607C66663C00; font64[7]  = 64'h7E060C1830303000;
    font64[8]  = 64'h3C66663C66663C00; font64[9]  = 64'h3C66663E060C3800;
    font64[10] = 64'h183C66667E666600; font64[11] = 64'h7C66667C66667C00;
    font64[12] = 64'h3C66606060663C00; font64[13] = 64'h786C6666666C7800;
    font64[14] = 64'h7E60607C60607E00; font64[15] = 64'h7E6060607C606000;
    for (int i = 0; i < 11; i++) snap_words[i] = '0;

    rst = 1'b0;
    bus_words[0] = 16'h1234;
    for (int i = 1; i < 10; i++) bus_words[i] = 16'($urandom);
    bus_words[10] = 16'hF000;
    drive_bus();

    repeat (10) tick();
    #5 rst = 1'b1;

    // Frame 0 shows the zero snapshot; frame 1 shows 1234 and the RA row.
    while (k < FRAME + 100 * HT) tick();
    bus_words[0] = 16'hABCD;
    for (int i = 1; i < 10; i++) bus_words[i] = 16'($urandom);
    drive_bus();
    while (k < 2 * FRAME + 20 * HT) tick();

    mid_reset_done = 1'b1;
    #3 rst = 1'b0;
    #2 check("async_reset", {19'd0, vif.hs, vif.vs, vif.r, vif.g, vif.b}, {19'd0, RST_VAL});
    repeat (3) tick();
    #5 rst = 1'b1;
    while (k < 20 * HT + 40) tick();

    check("ra_F_row0", {16'd0, pat[31:16]}, 32'b0011111111111100);
    check("ra_0_row0", {16'd0, pat[15:0]},  32'b0000111111110000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
